// File: rtl/sdram_arb_pkg.sv
// Shared types and default parameters for the multi-port SDRAM host arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } arb_state_t;

   localparam int DEF_NPORTS     = 4;
   localparam int DEF_AW         = 24;
   localparam int DEF_DW         = 16;
   localparam int DEF_RD_LATENCY = 8;
   localparam int DEF_WR_GAP     = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request after ptr, wrapping modulo NPORTS.
module rr_picker
   import sdram_arb_pkg::*;
#(
   parameter int NPORTS = DEF_NPORTS,
   parameter int PW     = $clog2(NPORTS)
) (
   input  logic [NPORTS-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [NPORTS-1:0] winner_onehot,
   output logic [PW-1:0]     winner_idx,
   output logic              any
);

   logic [PW-1:0] cand_s;

   // Scan ptr+1 .. ptr+NPORTS so the previous winner is considered last.
   always_comb begin
      winner_onehot = '0;
      winner_idx    = '0;
      any           = 1'b0;
      cand_s        = '0;
      for (int i = 1; i <= NPORTS; i++) begin
         cand_s = PW'((int'(ptr) + i) % NPORTS);
         if (!any && req[cand_s]) begin
            any                   = 1'b1;
            winner_idx            = cand_s;
            winner_onehot[cand_s] = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin front end for a single-port SDRAM controller; one command in flight,
// read data returned to the owning port after a fixed latency.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NPORTS     = DEF_NPORTS,
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int RD_LATENCY = DEF_RD_LATENCY,
   parameter int WR_GAP     = DEF_WR_GAP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    req,
   input  logic [NPORTS-1:0]    we,
   input  logic [NPORTS*AW-1:0] addr,
   input  logic [NPORTS*DW-1:0] wdata,
   output logic [NPORTS-1:0]    gnt,
   output logic [NPORTS-1:0]    rvalid,
   output logic [DW-1:0]        rdata,
   output logic [AW-1:0]        mem_haddr,
   output logic [DW-1:0]        mem_data_input,
   output logic                 mem_rd_enable,
   output logic                 mem_wr_enable,
   input  logic                 mem_busy,
   input  logic [DW-1:0]        mem_data_output
);

   localparam int PW = $clog2(NPORTS);
   localparam int CW = $clog2(max_int(RD_LATENCY, WR_GAP) + 1);
   localparam logic [CW-1:0] CNT_RD   = CW'(RD_LATENCY);
   localparam logic [CW-1:0] CNT_WR   = CW'(WR_GAP);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_INIT = PW'(NPORTS - 1);

   arb_state_t          state_r, state_s;
   logic [CW-1:0]       cnt_r, cnt_s;
   logic [PW-1:0]       ptr_r, ptr_s;
   logic [PW-1:0]       owner_r, owner_s;
   logic [NPORTS-1:0]   gnt_r, gnt_s;
   logic [NPORTS-1:0]   rvalid_r, rvalid_s;
   logic [DW-1:0]       rdata_r, rdata_s;
   logic [AW-1:0]       haddr_r, haddr_s;
   logic [DW-1:0]       din_r, din_s;
   logic                rd_en_r, rd_en_s;
   logic                wr_en_r, wr_en_s;

   logic [NPORTS-1:0]   win_onehot_s;
   logic [PW-1:0]       win_idx_s;
   logic                any_s;

   rr_picker #(
      .NPORTS (NPORTS),
      .PW     (PW)
   ) u_picker (
      .req           (req),
      .ptr           (ptr_r),
      .winner_onehot (win_onehot_s),
      .winner_idx    (win_idx_s),
      .any           (any_s)
   );

   // Next-state and next-output decode; pulses default low, address/data hold.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      ptr_s    = ptr_r;
      owner_s  = owner_r;
      gnt_s    = '0;
      rvalid_s = '0;
      rd_en_s  = 1'b0;
      wr_en_s  = 1'b0;
      rdata_s  = rdata_r;
      haddr_s  = haddr_r;
      din_s    = din_r;
      case (state_r)
         IDLE: begin
            if (any_s && !mem_busy) begin
               gnt_s   = win_onehot_s;
               ptr_s   = win_idx_s;
               owner_s = win_idx_s;
               haddr_s = addr[win_idx_s*AW +: AW];
               din_s   = wdata[win_idx_s*DW +: DW];
               if (we[win_idx_s]) begin
                  wr_en_s = 1'b1;
                  cnt_s   = CNT_WR;
                  state_s = WR_WAIT;
               end else begin
                  rd_en_s = 1'b1;
                  cnt_s   = CNT_RD;
                  state_s = RD_WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RD_WAIT: begin
            // Last wait cycle: controller data is valid at this edge.
            if (cnt_r <= CNT_ONE) begin
               cnt_s             = '0;
               rdata_s           = mem_data_output;
               rvalid_s[owner_r] = 1'b1;
               state_s           = IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         WR_WAIT: begin
            if (cnt_r <= CNT_ONE) begin
               cnt_s   = '0;
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            cnt_s   = '0;
            state_s = IDLE;
         end
      endcase
   end

   // State, counter, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         ptr_r    <= PTR_INIT;
         owner_r  <= '0;
         gnt_r    <= '0;
         rvalid_r <= '0;
         rdata_r  <= '0;
         haddr_r  <= '0;
         din_r    <= '0;
         rd_en_r  <= 1'b0;
         wr_en_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         ptr_r    <= ptr_s;
         owner_r  <= owner_s;
         gnt_r    <= gnt_s;
         rvalid_r <= rvalid_s;
         rdata_r  <= rdata_s;
         haddr_r  <= haddr_s;
         din_r    <= din_s;
         rd_en_r  <= rd_en_s;
         wr_en_r  <= wr_en_s;
      end
   end

   assign gnt            = gnt_r;
   assign rvalid         = rvalid_r;
   assign rdata          = rdata_r;
   assign mem_haddr      = haddr_r;
   assign mem_data_input = din_r;
   assign mem_rd_enable  = rd_en_r;
   assign mem_wr_enable  = wr_en_r;

endmodule
